// File: rtl/pp_seg_reader_pkg.sv
// Shared types and constants for the ping-pong segment reader.
package pp_seg_reader_pkg;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ARM,
        RD_RUN,
        RD_REL
    } pp_rd_state_e;

    // Output FIFO depth; also bounds reads outstanding against it.
    localparam int unsigned PP_RD_FIFO_D = 3;

endpackage

// File: rtl/pp_seg_reader_fifo3.sv
// Three-entry stream FIFO holding {last, data}; push and pop may coincide.
module sa_stream_fifo3
    import pp_seg_reader_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         empty
);
    localparam logic [1:0] LAST_IDX = 2'(PP_RD_FIFO_D - 1);

    logic [W-1:0] mem_q [PP_RD_FIFO_D];
    logic [W-1:0] mem_d [PP_RD_FIFO_D];
    logic [1:0]   wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = (wr_q == LAST_IDX) ? 2'd0 : wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = (rd_q == LAST_IDX) ? 2'd0 : rd_q + 2'd1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign count    = cnt_q;
    assign empty    = (cnt_q == 2'd0);

endmodule

// File: rtl/pp_seg_reader.sv
// Consumer-side driver for the ping-pong buffer: reads one bank segment and
// re-times the 1-cycle BRAM read latency into a valid/ready stream with last.
module pp_seg_reader
    import pp_seg_reader_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned ADDR_W          = $clog2(DEPTH),
    parameter bit          USE_CONS_COMMIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       seg_words,
    output logic              busy,
    output logic              done,
    output logic              consume_req,
    input  logic              consume_busy,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_rdata,
    output logic              cons_commit,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);
    localparam int unsigned      CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    pp_rd_state_e     state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d, issued_q, issued_d, beat_q, beat_d, cap_q, cap_d;
    logic             inflight_q, inflight_d, rel_first_q, rel_first_d;
    logic [CNT_W-1:0] n_eff;
    logic             issue, room, hs, fifo_empty;
    logic [1:0]       fifo_cnt;
    logic [DATA_W:0]  push_word, pop_word;

    always_comb begin
        if (seg_words == 32'd0 || seg_words > 32'(DEPTH)) begin
            n_eff = DEPTH_N;
        end else begin
            n_eff = seg_words[CNT_W-1:0];
        end
    end

    // Registered occupancy only, so m_tready never reaches rd_en combinationally.
    assign room  = ({1'b0, fifo_cnt} + {2'b00, inflight_q}) < 3'(PP_RD_FIFO_D);
    assign issue = (state_q == RD_RUN) && (issued_q < n_q) && room;
    assign hs    = m_tvalid && m_tready;

    assign push_word = {(cap_q == n_q - ONE), rd_rdata};

    sa_stream_fifo3 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(push_word),
        .pop      (hs),
        .pop_data (pop_word),
        .count    (fifo_cnt),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        issued_d    = issued_q;
        beat_d      = beat_q;
        cap_d       = cap_q;
        inflight_d  = issue;
        rel_first_d = 1'b0;
        consume_req = 1'b0;
        done        = 1'b0;

        if (inflight_q) cap_d = cap_q + ONE;
        if (hs)         beat_d = beat_q + ONE;

        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    state_d  = RD_ARM;
                    n_d      = n_eff;
                    issued_d = '0;
                    beat_d   = '0;
                    cap_d    = '0;
                end
            end
            RD_ARM: begin
                consume_req = !consume_busy;
                if (consume_busy) state_d = RD_RUN;
            end
            RD_RUN: begin
                if (issue) issued_d = issued_q + ONE;
                if (hs && beat_q == n_q - ONE) begin
                    state_d     = RD_REL;
                    rel_first_d = 1'b1;
                end
            end
            RD_REL: begin
                if (!consume_busy) begin
                    done    = 1'b1;
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            n_q         <= '0;
            issued_q    <= '0;
            beat_q      <= '0;
            cap_q       <= '0;
            inflight_q  <= 1'b0;
            rel_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            issued_q    <= issued_d;
            beat_q      <= beat_d;
            cap_q       <= cap_d;
            inflight_q  <= inflight_d;
            rel_first_q <= rel_first_d;
        end
    end

    assign busy        = (state_q != RD_IDLE);
    assign rd_en       = issue;
    assign rd_addr     = issue ? issued_q[ADDR_W-1:0] : '0;
    assign cons_commit = USE_CONS_COMMIT && (state_q == RD_REL) && rel_first_q;
    assign m_tvalid    = !fifo_empty;
    assign m_tdata     = fifo_empty ? '0 : pop_word[DATA_W-1:0];
    assign m_tlast     = !fifo_empty && pop_word[DATA_W];

endmodule
